// File: rtl/timer_capture_if.sv
// Register access bus for timer_capture: single-cycle write and combinational read.
// The CPU side uses the master modport, the peripheral the slave modport.
interface timer_capture_if;
   logic        write_i;
   logic [31:0] write_data_i;
   logic [2:0]  write_address_i;
   logic [3:0]  write_strobe_i;
   logic        write_error_o;
   logic        read_i;
   logic [2:0]  read_address_i;
   logic [31:0] read_data_o;
   logic        read_error_o;

   modport master (
      output write_i, write_data_i, write_address_i, write_strobe_i, read_i, read_address_i,
      input  write_error_o, read_data_o, read_error_o
   );

   modport slave (
      input  write_i, write_data_i, write_address_i, write_strobe_i, read_i, read_address_i,
      output write_error_o, read_data_o, read_error_o
   );
endinterface

// File: rtl/timer_capture.sv
// Input-capture timer: time-stamps edges of capture_i against a free-running 64-bit
// counter and queues the timestamps in a FIFO drained through the register bus.
module timer_capture #(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           capture_i,
   timer_capture_if.slave bus_if,
   output logic           interrupt_o
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   localparam logic [2:0] AddrCapLo  = 3'd0;
   localparam logic [2:0] AddrCapHi  = 3'd1;
   localparam logic [2:0] AddrCntLo  = 3'd2;
   localparam logic [2:0] AddrCntHi  = 3'd3;
   localparam logic [2:0] AddrConfig = 3'd4;
   localparam logic [2:0] AddrStatus = 3'd5;

   logic [63:0]            counter_q, counter_d;
   logic                   cfg_en_q, cfg_en_d;
   logic [1:0]             cfg_edge_q, cfg_edge_d;
   logic                   cfg_irq_q, cfg_irq_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic [63:0]            mem_q [FIFO_DEPTH];
   logic [63:0]            mem_d [FIFO_DEPTH];
   logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]        count_q, count_d;
   logic                   ovf_q, ovf_d;
   logic                   irq_q, irq_d;

   logic        wr_err, wr_ok, clear;
   logic [31:0] wmask;
   logic        synced, rise, fall, push, push_ok, pop;
   logic        fifo_empty, fifo_full;
   logic [63:0] head;

   // Bus write decode
   always_comb begin
      wr_err = bus_if.write_i &
               ((bus_if.write_address_i > AddrStatus) ||
                (bus_if.write_address_i == AddrCapLo) ||
                (bus_if.write_address_i == AddrCapHi) ||
                (bus_if.write_address_i == AddrStatus));
      wr_ok  = bus_if.write_i & ~wr_err;
      wmask  = {{8{bus_if.write_strobe_i[3]}}, {8{bus_if.write_strobe_i[2]}},
                {8{bus_if.write_strobe_i[1]}}, {8{bus_if.write_strobe_i[0]}}};
      clear  = wr_ok && (bus_if.write_address_i == AddrConfig) &&
               bus_if.write_strobe_i[0] && bus_if.write_data_i[4];
   end

   assign bus_if.write_error_o = wr_err;

   // Counter: a register write replaces the increment for that cycle
   always_comb begin
      counter_d = counter_q;
      if (cfg_en_q) begin
         counter_d = counter_q + 64'd1;
      end
      if (wr_ok && (bus_if.write_address_i == AddrCntLo)) begin
         counter_d = {counter_q[63:32],
                      (counter_q[31:0] & ~wmask) | (bus_if.write_data_i & wmask)};
      end else if (wr_ok && (bus_if.write_address_i == AddrCntHi)) begin
         counter_d = {(counter_q[63:32] & ~wmask) | (bus_if.write_data_i & wmask),
                      counter_q[31:0]};
      end
   end

   always_comb begin
      cfg_en_d   = cfg_en_q;
      cfg_edge_d = cfg_edge_q;
      cfg_irq_d  = cfg_irq_q;
      if (wr_ok && (bus_if.write_address_i == AddrConfig) && bus_if.write_strobe_i[0]) begin
         cfg_en_d   = bus_if.write_data_i[0];
         cfg_edge_d = bus_if.write_data_i[2:1];
         cfg_irq_d  = bus_if.write_data_i[3];
      end
   end

   // Synchroniser and edge detect run regardless of enable, so enabling sees no false edge
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], capture_i};
      synced = sync_q[SYNC_STAGES-1];
      prev_d = synced;
      rise   = synced & ~prev_q;
      fall   = ~synced & prev_q;
      push   = cfg_en_q & ((cfg_edge_q[0] & rise) | (cfg_edge_q[1] & fall));
   end

   // FIFO: a pop frees a slot for a same-cycle push when full; clear wins over both
   always_comb begin
      fifo_empty = (count_q == '0);
      fifo_full  = (count_q == CntW'(FIFO_DEPTH));
      pop        = bus_if.read_i && (bus_if.read_address_i == AddrCapHi) && !fifo_empty;
      push_ok    = push && (!fifo_full || pop);

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = counter_q;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
         end
         if (push_ok && !pop) begin
            count_d = count_q + CntW'(1);
         end else if (pop && !push_ok) begin
            count_d = count_q - CntW'(1);
         end
         if (push && !push_ok) begin
            ovf_d = 1'b1;
         end
      end
      irq_d = cfg_irq_q & ~fifo_empty;
   end

   // Combinational read port
   always_comb begin
      head = fifo_empty ? 64'd0 : mem_q[rd_ptr_q];
      unique case (bus_if.read_address_i)
         AddrCapLo:  bus_if.read_data_o = head[31:0];
         AddrCapHi:  bus_if.read_data_o = head[63:32];
         AddrCntLo:  bus_if.read_data_o = counter_q[31:0];
         AddrCntHi:  bus_if.read_data_o = counter_q[63:32];
         AddrConfig: bus_if.read_data_o = {28'd0, cfg_irq_q, cfg_edge_q, cfg_en_q};
         AddrStatus: bus_if.read_data_o = {24'd0, 5'(count_q), ovf_q, fifo_full, fifo_empty};
         default:    bus_if.read_data_o = 32'd0;
      endcase
      bus_if.read_error_o = bus_if.read_i & (bus_if.read_address_i > AddrStatus);
   end

   assign interrupt_o = irq_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         counter_q  <= '0;
         cfg_en_q   <= 1'b0;
         cfg_edge_q <= '0;
         cfg_irq_q  <= 1'b0;
         sync_q     <= '0;
         prev_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         counter_q  <= counter_d;
         cfg_en_q   <= cfg_en_d;
         cfg_edge_q <= cfg_edge_d;
         cfg_irq_q  <= cfg_irq_d;
         sync_q     <= sync_d;
         prev_q     <= prev_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         irq_q      <= irq_d;
      end
   end

   // Storage needs no reset: entries are only visible through count_q
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: doc/timer_capture.md
Name: timer_capture

Overview:
Input-capture peripheral, the receive-direction counterpart of the compare/interrupt timer. It time-stamps edges on an external `capture_i` pin against a free-running 64-bit counter and queues the timestamps in a small FIFO. The CPU drains the FIFO through the standard peripheral register interface. An interrupt signals that timestamps are pending.

Parameters:
FIFO_DEPTH, 4, timestamp entries; power of two, >= 2
SYNC_STAGES, 2, flops in the `capture_i` synchroniser; >= 2

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset; synchronous, active-high
capture_i  in  1  asynchronous external event input
write_i  in  1  register write request, single cycle
write_data_i  in  32  write data
write_address_i  in  3  write register index
write_strobe_i  in  4  byte enables for write_data_i
write_error_o  out  1  write to illegal or read-only address (combinational)
read_i  in  1  register read request, single cycle
read_address_i  in  3  read register index
read_data_o  out  32  read data (combinational from read_address_i)
read_error_o  out  1  read of address > 5 (combinational)
interrupt_o  out  1  level interrupt

Behaviour:
Register map:
- 0 CAPTURE_LOW: RO, FIFO head [31:0], 0 when empty.
- 1 CAPTURE_HIGH: RO, FIFO head [63:32], 0 when empty. A read pops the head at the clock edge if the FIFO is non-empty.
- 2 COUNTER_LOW: RW.
- 3 COUNTER_HIGH: RW.
- 4 CONFIG: RW.
  - [0] enable
  - [2:1] edge_sel: 00 none, 01 rising, 10 falling, 11 both
  - [3] interrupt_enable
  - [4] clear: write-1, self-clearing, always reads 0
- 5 STATUS: RO.
  - [0] empty
  - [1] full
  - [2] overflow (sticky)
  - [7:3] count
- Other read bits are 0.

Errors:
- write_error_o = write_i & (address > 5 | address in {0,1,5}); such writes change nothing.
- read_error_o = read_i & (address > 5); read_data_o = 0 in that case.

Writes:
- Per-byte using write_strobe_i; unstrobed bytes keep their value.
- CONFIG uses bytes [0] only.

Reset (rst_i high at a clock edge):
- Counter = 0, CONFIG = 0, FIFO empty, overflow = 0, sync/edge flops = 0.
- interrupt_o = 0.

Counter:
- Increments by 1 each cycle while enable = 1; wraps 2^64-1 -> 0; holds while enable = 0.
- A write to COUNTER_LOW/HIGH takes priority over increment: the merged value is loaded with no increment that cycle.

Capture path:
- `capture_i` passes through SYNC_STAGES flops, then one "previous" flop.
- Edge detect compares the synced value with the previous flop (combinational).
- The synchroniser and previous flop run regardless of enable, so enabling never produces a spurious edge.
- A qualifying edge with enable = 1 and edge_sel matching pushes the current counter value at that clock edge.
- Net latency: if `capture_i` changes before clock edge E0, the timestamp equals the counter value in the cycle preceding E0 plus SYNC_STAGES.
- Pushed data is visible on CAPTURE_* on the next cycle.

FIFO:
- Push when full: sample dropped, overflow set.
- Push and pop in the same cycle when full: both occur, no overflow.
- Pop when empty: ignored.
- Push and pop in the same cycle when empty: push only.
- Clear (CONFIG write with bit 4 and byte strobe 0): empties the FIFO and clears overflow. It wins over a same-cycle push and pop. The other CONFIG fields are written in that same cycle.
- Entries wrap via log2(FIFO_DEPTH)-bit pointers; count is separate, 0..FIFO_DEPTH.

Interrupt:
- interrupt_o = interrupt_enable & !empty, registered from the FIFO state; it deasserts the cycle after the last pop.

Reset mid-operation:
- Any in-flight edge or push is lost; state returns to the reset values above.

Test Plan:
1. Reset, write CONFIG = 0x0B (enable, rising, irq_en), COUNTER_LOW = 0. Raise `capture_i` before the edge where the counter reads 100 -> CAPTURE_LOW = 102, CAPTURE_HIGH = 0, STATUS count = 1, interrupt_o = 1. Read CAPTURE_HIGH -> empty = 1; interrupt_o = 0 one cycle later.
2. edge_sel = 11, pulse `capture_i` high for 10 cycles -> two entries differing by 10. edge_sel = 10 with the same stimulus -> only the falling timestamp is recorded.
3. Generate 5 rising edges with no reads (FIFO_DEPTH = 4) -> full = 1, overflow = 1, count = 4, oldest 4 timestamps retained. Write CONFIG = 0x1B -> empty = 1, overflow = 0, enable still 1.
4. With FIFO full, pop and push in the same cycle -> count stays 4, overflow stays 0, order preserved.
5. Write COUNTER_HIGH = 0xFFFFFFFF and COUNTER_LOW = 0xFFFFFFFE, enable -> two cycles later the counter reads 0. Write COUNTER_LOW with strobe 0001, data 0xAB -> only byte 0 changes and no increment occurs that cycle.
6. Write address 1, write address 6, read address 7 -> write_error_o = 1 twice, read_error_o = 1 with read_data_o = 0. Assert rst_i mid-capture -> all registers 0 and interrupt_o = 0 on the next cycle.
